// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane: load/store unit between the execute-stage ALU and a
// word-wide data memory of DEPTH_WORDS 32-bit words.
//
// One request in flight at a time. Word accesses go straight to the memory
// port. Byte/halfword stores do a read-modify-write. Loads return a sign- or
// zero-extended lane. Misaligned, out-of-range or illegal-funct3 requests
// answer with resp_err_o and never touch memory.
//
// Handshake: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both high. req_ready_o is high only in IDLE, and request
// inputs are ignored otherwise. resp_valid_o is a single-cycle pulse with no
// backpressure. resp_err_o and resp_rdata_o are meaningful while it is high.
//
// Ports:
//   clk, rst_i           clock, synchronous active-high reset
//   req_*                request: valid/ready, store, funct3, addr, wdata
//   resp_*               response pulse, extended load data, error flag
//   dmem_*               memory port: word address, write enable/data, rdata
//   dbg_state_o          FSM state (0 IDLE, 1 ACCESS, 2 WRITE, 3 RESP)
module lsu_byte_lane #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_store_i,
  input  logic [2:0]  req_funct3_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_err_o,
  output logic [31:0] dmem_addr_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_wdata_o,
  input  logic [31:0] dmem_rdata_i,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH_WORDS * 4);

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  funct3_q;
  logic        store_q;
  logic        err_q;
  logic [31:0] old_q;
  logic [31:0] rdata_q;
  logic [31:0] last_addr_q;

  logic        req_err;
  logic        f3_illegal;
  logic        misaligned;
  logic [31:0] word_addr;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Request check on the raw inputs, so an error goes straight to RESP.
  always_comb begin
    f3_illegal = (req_funct3_i == 3'b011) || (req_funct3_i == 3'b110) ||
                 (req_funct3_i == 3'b111) || (req_funct3_i[2] && req_store_i);
    misaligned = ((req_funct3_i[1:0] == 2'b01) && req_addr_i[0]) ||
                 ((req_funct3_i[1:0] == 2'b10) && (req_addr_i[1:0] != 2'b00));
    req_err    = f3_illegal || misaligned || (req_addr_i >= ADDR_LIMIT);
  end

  assign word_addr = {addr_q[31:2], 2'b00};

  // Load lane extraction from the word currently presented by memory.
  always_comb begin
    byte_sel = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    half_sel = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'h0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'h0, half_sel};
      default: load_val = dmem_rdata_i;
    endcase
  end

  // Sub-word store merge: only the addressed lane of the old word changes.
  always_comb begin
    merged = old_q;
    if (funct3_q[1:0] == 2'b00) begin
      merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      funct3_q    <= 3'b000;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
      old_q       <= 32'h0;
      rdata_q     <= 32'h0;
      last_addr_q <= 32'h0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            wdata_q  <= req_wdata_i;
            funct3_q <= req_funct3_i;
            store_q  <= req_store_i;
            err_q    <= req_err;
            if (req_err) rdata_q <= 32'h0;
          end
        end
        S_ACCESS: begin
          last_addr_q <= word_addr;
          if (!store_q) begin
            rdata_q <= load_val;
          end else if (funct3_q[1:0] == 2'b10) begin
            rdata_q <= 32'h0;
          end else begin
            old_q <= dmem_rdata_i;
          end
        end
        S_WRITE: begin
          last_addr_q <= word_addr;
          rdata_q     <= 32'h0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_err_o   = 1'b0;
    dmem_addr_o  = last_addr_q;
    dmem_we_o    = 1'b0;
    dmem_wdata_o = 32'h0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = req_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        dmem_addr_o = word_addr;
        if (!store_q) begin
          state_d = S_RESP;
        end else if (funct3_q[1:0] == 2'b10) begin
          dmem_we_o    = 1'b1;
          dmem_wdata_o = wdata_q;
          state_d      = S_RESP;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        dmem_addr_o  = word_addr;
        dmem_we_o    = 1'b1;
        dmem_wdata_o = merged;
        state_d      = S_RESP;
      end
      S_RESP: begin
        resp_valid_o = 1'b1;
        resp_err_o   = err_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_rdata_o = rdata_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_lsu_byte_lane.sv
// Bench for lsu_byte_lane: directed scenarios plus randomized traffic, all
// checked against a byte-level reference memory model kept in the bench.
module tb_lsu_byte_lane;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_store_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = 32'h0;
  logic [31:0] req_wdata_i = 32'h0;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;
  logic        resp_err_o;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [31:0] dmem_wdata_o;
  logic [31:0] dmem_rdata_i;
  logic [1:0]  dbg_state_o;

  lsu_byte_lane #(.DEPTH_WORDS(64)) dut (
    .clk          (clk),
    .rst_i        (rst_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_store_i  (req_store_i),
    .req_funct3_i (req_funct3_i),
    .req_addr_i   (req_addr_i),
    .req_wdata_i  (req_wdata_i),
    .resp_valid_o (resp_valid_o),
    .resp_rdata_o (resp_rdata_o),
    .resp_err_o   (resp_err_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_rdata_i (dmem_rdata_i),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- memory attached to the DUT ----------------
  logic [31:0] mem [64];
  assign dmem_rdata_i = mem[dmem_addr_o[7:2]];
  always @(posedge clk) if (dmem_we_o) mem[dmem_addr_o[7:2]] <= dmem_wdata_o;

  // Write monitor: we_edge is the clock edge index at which the write lands.
  int          we_cnt = 0;
  int          we_edge = 0;
  logic [31:0] we_data = 32'h0;
  logic [31:0] we_addr = 32'h0;
  always @(negedge clk) begin
    if (dmem_we_o) begin
      we_cnt  = we_cnt + 1;
      we_edge = cyc + 1;
      we_data = dmem_wdata_o;
      we_addr = dmem_addr_o;
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [64];
  logic [31:0] exp_q [$];
  int total = 0;
  int bad = 0;

  task automatic set_word(input int idx, input logic [31:0] val);
    mem[idx] <= val;
    ref_mem[idx] = val;
  endtask

  // Behaviour from the ISA rules: access size 1<<funct3[1:0], natural
  // alignment, byte-shift by address, sign-extend unless funct3[2].
  task automatic ref_model(input logic st, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic e, output logic [31:0] rd,
                           output int lat, output int wr,
                           output logic [31:0] wword);
    int size;
    int sh;
    bit legal;
    longint unsigned v;
    longint unsigned lane_mask;
    logic [31:0] word;
    logic [31:0] mask;
    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) && !(st && f3 >= 4);
    size  = 1 << f3[1:0];
    e     = !legal || (addr % size != 0) || (addr >= 256);
    rd    = 32'h0;
    wr    = 0;
    wword = 32'h0;
    lat   = 1;
    if (e) return;
    word      = ref_mem[addr / 4];
    sh        = 8 * int'(addr % 4);
    lane_mask = (64'd1 << (8 * size)) - 1;
    if (!st) begin
      v = (longint'(word) >> sh) & lane_mask;
      if (f3 < 4 && size < 4 && v[8*size-1]) v = v - (64'd1 << (8 * size));
      rd  = v[31:0];
      lat = 2;
    end else begin
      mask  = 32'(lane_mask << sh);
      wword = (word & ~mask) | ((wdata << sh) & mask);
      ref_mem[addr / 4] = wword;
      wr  = 1;
      lat = (size == 4) ? 2 : 3;
    end
  endtask

  // ---------------- driver ----------------
  task automatic do_req(input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
    logic        e;
    logic [31:0] rd;
    logic [31:0] ww;
    logic [31:0] exp_rd;
    int lat;
    int wr;
    int w;
    int c0;
    int wc0;
    bit got;
    ref_model(st, f3, addr, wdata, e, rd, lat, wr, ww);
    exp_q.push_back(rd);
    w = 0;
    while (!req_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    total++;
    if (!req_ready_o) begin
      bad++;
      $display("FAIL %s ready_timeout got=%0b want=1", tag, req_ready_o);
    end
    req_valid_i  = 1'b1;
    req_store_i  = st;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wdata;
    c0  = cyc;
    wc0 = we_cnt;
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (i == 0) req_valid_i = 1'b0;
      if (resp_valid_o) got = 1;
    end
    exp_rd = exp_q.pop_front();
    total++;
    if (!got) begin
      bad++;
      $display("FAIL %s resp_timeout got=none want=pulse", tag);
      return;
    end
    total++;
    if (cyc - c0 !== lat) begin
      bad++;
      $display("FAIL %s latency got=%0d want=%0d", tag, cyc - c0, lat);
    end
    total++;
    if (resp_err_o !== e) begin
      bad++;
      $display("FAIL %s err got=%0b want=%0b", tag, resp_err_o, e);
    end
    total++;
    if (resp_rdata_o !== exp_rd) begin
      bad++;
      $display("FAIL %s rdata got=%h want=%h", tag, resp_rdata_o, exp_rd);
    end
    total++;
    if (we_cnt - wc0 !== wr) begin
      bad++;
      $display("FAIL %s write_count got=%0d want=%0d", tag, we_cnt - wc0, wr);
    end
    if (wr == 1 && we_cnt - wc0 == 1) begin
      total++;
      if (we_data !== ww || we_addr !== {addr[31:2], 2'b00} || we_edge !== c0 + lat) begin
        bad++;
        $display("FAIL %s write got=%h@%h edge%0d want=%h@%h edge%0d", tag,
                 we_data, we_addr, we_edge - c0, ww, {addr[31:2], 2'b00}, lat);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 64; i++) set_word(i, 32'h0);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    total++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || resp_err_o !== 1'b0 ||
        resp_rdata_o !== 32'h0 || dmem_we_o !== 1'b0 || dmem_addr_o !== 32'h0 ||
        dmem_wdata_o !== 32'h0 || dbg_state_o !== 2'd0) begin
      bad++;
      $display("FAIL reset got=rdy%0b v%0b e%0b rd%h we%0b a%h wd%h st%0d want=1 0 0 0 0 0 0 0",
               req_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, dmem_we_o,
               dmem_addr_o, dmem_wdata_o, dbg_state_o);
    end
  endtask

  task automatic test_lw_hit();
    set_word(4, 32'h0000_6666);
    @(negedge clk);
    do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_hit");
    @(negedge clk);
    total++;
    if (resp_valid_o !== 1'b0 || resp_rdata_o !== 32'h0000_6666) begin
      bad++;
      $display("FAIL rdata_hold got=v%0b %h want=v0 00006666", resp_valid_o, resp_rdata_o);
    end
  endtask

  task automatic test_extension();
    set_word(4, 32'h0000_80F0);
    @(negedge clk);
    do_req(1'b0, 3'b000, 32'h10, 32'h0, "lb_10");
    do_req(1'b0, 3'b100, 32'h10, 32'h0, "lbu_10");
    do_req(1'b0, 3'b001, 32'h10, 32'h0, "lh_10");
    do_req(1'b0, 3'b101, 32'h10, 32'h0, "lhu_10");
    do_req(1'b0, 3'b000, 32'h11, 32'h0, "lb_11");
  endtask

  task automatic test_sb_rmw();
    set_word(4, 32'h1122_3344);
    @(negedge clk);
    do_req(1'b1, 3'b000, 32'h12, 32'hAAAA_AA55, "sb_rmw");
    total++;
    if (mem[4] !== 32'h1155_3344) begin
      bad++;
      $display("FAIL sb_mem got=%h want=11553344", mem[4]);
    end
  endtask

  task automatic test_sh_then_lw();
    set_word(8, 32'h0);
    @(negedge clk);
    do_req(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, "sh_22");
    do_req(1'b0, 3'b010, 32'h20, 32'h0, "lw_after_sh");
  endtask

  task automatic test_errors();
    int wc0;
    wc0 = we_cnt;
    do_req(1'b0, 3'b010, 32'h13, 32'h0, "err_lw_13");
    do_req(1'b1, 3'b001, 32'h15, 32'h1234_5678, "err_sh_15");
    do_req(1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, "err_sw_100");
    do_req(1'b1, 3'b100, 32'h10, 32'h0000_00FF, "err_store_f3_100");
    do_req(1'b0, 3'b011, 32'h10, 32'h0, "err_f3_011");
    total++;
    if (we_cnt !== wc0) begin
      bad++;
      $display("FAIL err_no_write got=%0d want=%0d", we_cnt - wc0, 0);
    end
  endtask

  task automatic test_reset_mid_sb();
    int wc0;
    set_word(6, 32'hCAFE_F00D);
    @(negedge clk);
    wc0 = we_cnt;
    req_valid_i  = 1'b1;
    req_store_i  = 1'b1;
    req_funct3_i = 3'b000;
    req_addr_i   = 32'h19;
    req_wdata_i  = 32'h0000_0012;
    @(negedge clk);
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    total++;
    if (req_ready_o !== 1'b1 || resp_valid_o !== 1'b0 || dmem_we_o !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_sb got=rdy%0b v%0b we%0b want=1 0 0", req_ready_o, resp_valid_o, dmem_we_o);
    end
    repeat (2) @(negedge clk);
    total++;
    if (we_cnt !== wc0) begin
      bad++;
      $display("FAIL rst_mid_sb_write got=%0d want=0", we_cnt - wc0);
    end
    do_req(1'b0, 3'b010, 32'h18, 32'h0, "lw_after_rst");
  endtask

  // Randomized back-to-back traffic: requests go in at the first ready cycle.
  task automatic test_back_to_back();
    logic [2:0]  legal_f3 [5];
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        st;
    int r;
    int mism;
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    for (int n = 0; n < 250; n++) begin
      r    = $urandom_range(0, 19);
      f3   = (r < 18) ? legal_f3[r % 5] : 3'(3 + 3 * (r - 18));
      st   = ($urandom_range(0, 1) == 1) && (f3[2] == 1'b0 || r >= 18);
      addr = $urandom_range(0, 271);
      if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << f3[1:0]) - 1);
      do_req(st, f3, addr, $urandom, "rand");
    end
    mism = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) mism++;
    total++;
    if (mism != 0) begin
      bad++;
      $display("FAIL final_mem got=%0d_words_differ want=0", mism);
    end
  endtask

  initial begin
    test_reset();
    test_lw_hit();
    test_extension();
    test_sb_rmw();
    test_sh_then_lw();
    test_errors();
    test_reset_mid_sb();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
